reg_timer_multi: RTL
====================

// Module: reg_timer_multi
// PURPOSE
//  Parametrised successor of the Timer/Set time register for the digital watch.
//  Holds sec/min/hour fields with:
//   - three modes: Set, Timer (count up) and Countdown;
//   - per-field increment/decrement with button edge detection;
//   - 12/24-hour display and day-rollover/expiry flags.
//  Sits between the one-second prescaler/button debouncers and the display mux.
// PARAMETERS
//  SEC_MAX   59  terminal count of seconds field (decimal value)
//  MIN_MAX   59  terminal count of minutes field
//  HOUR_MAX  23  terminal count of hours field (internal hour range, 24h)
//  BCD       1   1: fields encoded as two BCD digits in 8 bits; 0: plain binary
// PORTS
//  clock        in   1  system clock, all state on rising edge
//  reset        in   1  asynchronous, active-low; clears all state
//  mode         in   2  00 Set, 01 Timer, 10 Countdown, 11 Hold (freeze, no change)
//  one_second   in   1  one-cycle strobe, once per second
//  field_sel    in   2  Set-mode target: 00 sec, 01 min, 10 hour, 11 none
//  inc_btn      in   1  debounced level; counts once per rising edge
//  dec_btn      in   1  debounced level; counts once per rising edge
//  clear        in   1  synchronous clear of all fields
//  hour12       in   1  1: hour_disp in 12h format; 0: 24h
//  second_data  out  8  seconds field
//  minute_data  out  8  minutes field
//  hour_data    out  8  hours field, always 0..HOUR_MAX
//  hour_disp    out  8  display hour (1..12 when hour12, else = hour_data)
//  pm           out  1  1 when hour_data >= 12 (valid in either format)
//  day_carry    out  1  one-cycle pulse on Timer wrap HOUR_MAX:MIN_MAX:SEC_MAX -> 0:0:0
//  expired      out  1  one-cycle pulse when Countdown reaches 0:0:0
// BEHAVIOUR
//  - Reset: all fields 0, edge-detect regs 0, day_carry/expired 0, pm 0.
//    hour_disp = 12 if hour12, else 0 (combinational from hour_data/hour12).
//  - Field regs update on the edge sampling the event; outputs registered, 1-cycle latency.
//  - Priority per cycle: clear > mode action. Clear zeroes fields, suppresses pulses.
//  - Timer: each one_second increments sec; carries ripple in same cycle, so
//    23:59:59 -> 00:00:00 in one edge with day_carry=1 the following cycle.
//  - Countdown: each one_second decrements with borrow (00:01:00 -> 00:00:59).
//    At 0:0:0 further ticks are ignored; fields stay 0.
//    expired fires once, on the transition into 0:0:0 only.
//  - Set: one_second ignored. inc/dec rising edge (reg prev value, 1-cycle detect)
//    adjusts the selected field only.
//    Wrap: max -> 0 on inc, 0 -> max on dec. No carry into other fields, no pulses.
//  - inc and dec edges in the same cycle: net no change.
//    Button edges are ignored outside Set mode, but the edge regs are still updated.
//  - Hold: nothing changes except edge regs.
//  - Mode switch mid-count: fields retained; next action follows the new mode.
//  - BCD=1: units digit wraps 9 -> 0 with tens increment; field compare uses the
//    BCD encoding of *_MAX. Illegal BCD codes never produced.
//  - 12h map: 0 -> 12, 1..12 -> same, 13..23 -> minus 12.
// STRUCTURE
//  - Package reg_timer_pkg: mode codes (MODE_SET/TIMER/DOWN/HOLD), field_sel
//    codes, bin-to-BCD constant helper function.
//  - Sub-module time_field_cnt (params MAX, BCD): up/down enables, wrap,
//    carry_out/borrow_out combinational, sync clear; instantiated 3x.
//  - Top: mode decode, button edge detect, carry chain, zero detect, 12h map, pulse regs.
// TESTING
//  1. Reset low mid-count at 12:34:56, Timer -> all outputs 0; hour_disp=12 with hour12=1.
//  2. Timer from 23:59:58, two ticks -> 23:59:59 then 00:00:00; day_carry high 1 cycle.
//  3. Countdown from 00:01:00, tick -> 00:00:59; from 00:00:01, tick -> 0:0:0,
//     expired 1 cycle; further ticks -> no change, no pulse.
//  4. Set, field_sel=hour, hour=0: dec edge -> 23; inc edge -> 0; minutes unchanged;
//     inc held high 10 cycles -> exactly one step.
//  5. Set: inc+dec same cycle -> no change. tick during Set -> no change.
//     Clear with tick in Timer -> 0:0:0.
//  6. hour12=1, hour_data 0/12/13/23 -> hour_disp 12/12/1/11, pm 0/1/1/1; repeat with BCD=0.

Source files
------------

// File: rtl/reg_timer_pkg.sv
// Shared codes and helpers for the watch time register: mode and field-select
// encodings plus a binary-to-BCD conversion used for terminal-count constants.
package reg_timer_pkg;

  typedef enum logic [1:0] {
    MODE_SET   = 2'b00,
    MODE_TIMER = 2'b01,
    MODE_DOWN  = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SEL_SEC  = 2'b00,
    SEL_MIN  = 2'b01,
    SEL_HOUR = 2'b10,
    SEL_NONE = 2'b11
  } field_sel_e;

  function automatic logic [7:0] bin_to_bcd(input int unsigned v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/time_field_cnt.sv
// One wrapping time field (sec, min or hour), binary or two-digit BCD.
// Terminal flags are ungated so the parent can build its own carry/borrow chain.
module time_field_cnt
  import reg_timer_pkg::*;
#(
  parameter int unsigned MAX = 59,
  parameter bit          BCD = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_up,
  input  logic       i_down,
  output logic [7:0] o_value,
  output logic       o_carry_out,
  output logic       o_borrow_out
);

  localparam logic [7:0] MaxCode = BCD ? bin_to_bcd(MAX) : 8'(MAX);

  logic [7:0] r_value;
  logic [7:0] w_inc;
  logic [7:0] w_dec;
  logic [7:0] w_next;

  always_comb begin
    w_inc = r_value + 8'd1;
    w_dec = r_value - 8'd1;
    if (BCD && r_value[3:0] == 4'd9) w_inc = {r_value[7:4] + 4'd1, 4'd0};
    if (BCD && r_value[3:0] == 4'd0) w_dec = {r_value[7:4] - 4'd1, 4'd9};
    if (r_value == MaxCode) w_inc = 8'd0;
    if (r_value == 8'd0) w_dec = MaxCode;
    w_next = r_value;
    if (i_up && !i_down) begin
      w_next = w_inc;
    end else if (i_down && !i_up) begin
      w_next = w_dec;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value <= 8'd0;
    end else if (i_clear) begin
      r_value <= 8'd0;
    end else begin
      r_value <= w_next;
    end
  end

  assign o_value      = r_value;
  assign o_carry_out  = (r_value == MaxCode);
  assign o_borrow_out = (r_value == 8'd0);

endmodule

// File: rtl/reg_timer_multi.sv
// Watch time register: Set / Timer / Countdown / Hold over sec:min:hour fields,
// with button edge detection, 12/24h display mapping and rollover/expiry pulses.
module reg_timer_multi
  import reg_timer_pkg::*;
#(
  parameter int unsigned SEC_MAX  = 59,
  parameter int unsigned MIN_MAX  = 59,
  parameter int unsigned HOUR_MAX = 23,
  parameter bit          BCD      = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_mode,
  input  logic       i_one_second,
  input  logic [1:0] i_field_sel,
  input  logic       i_inc_btn,
  input  logic       i_dec_btn,
  input  logic       i_clear,
  input  logic       i_hour12,
  output logic [7:0] o_second_data,
  output logic [7:0] o_minute_data,
  output logic [7:0] o_hour_data,
  output logic [7:0] o_hour_disp,
  output logic       o_pm,
  output logic       o_day_carry,
  output logic       o_expired
);

  logic r_inc_prev, r_dec_prev, r_day_carry, r_expired;
  logic w_inc_edge, w_dec_edge, w_set_inc, w_set_dec;
  logic w_tick_up, w_tick_dn, w_zero;
  logic w_sec_up, w_sec_dn, w_min_up, w_min_dn, w_hour_up, w_hour_dn;
  logic w_sec_max, w_min_max, w_hour_max, w_sec_zero, w_min_zero, w_hour_zero;
  logic [7:0] w_sec, w_min, w_hour;
  logic [7:0] w_hour_bin, w_disp_bin;

  assign w_inc_edge = i_inc_btn & ~r_inc_prev;
  assign w_dec_edge = i_dec_btn & ~r_dec_prev;
  // Simultaneous inc and dec edges cancel out.
  assign w_set_inc  = (i_mode == MODE_SET) & w_inc_edge & ~w_dec_edge;
  assign w_set_dec  = (i_mode == MODE_SET) & w_dec_edge & ~w_inc_edge;

  assign w_zero    = w_sec_zero & w_min_zero & w_hour_zero;
  assign w_tick_up = (i_mode == MODE_TIMER) & i_one_second;
  assign w_tick_dn = (i_mode == MODE_DOWN) & i_one_second & ~w_zero;

  assign w_sec_up  = w_tick_up | (w_set_inc & (i_field_sel == SEL_SEC));
  assign w_sec_dn  = w_tick_dn | (w_set_dec & (i_field_sel == SEL_SEC));
  assign w_min_up  = (w_tick_up & w_sec_max) | (w_set_inc & (i_field_sel == SEL_MIN));
  assign w_min_dn  = (w_tick_dn & w_sec_zero) | (w_set_dec & (i_field_sel == SEL_MIN));
  assign w_hour_up = (w_tick_up & w_sec_max & w_min_max)
                   | (w_set_inc & (i_field_sel == SEL_HOUR));
  assign w_hour_dn = (w_tick_dn & w_sec_zero & w_min_zero)
                   | (w_set_dec & (i_field_sel == SEL_HOUR));

  time_field_cnt #(.MAX(SEC_MAX), .BCD(BCD)) u_sec (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (i_clear),
    .i_up        (w_sec_up),
    .i_down      (w_sec_dn),
    .o_value     (w_sec),
    .o_carry_out (w_sec_max),
    .o_borrow_out(w_sec_zero)
  );

  time_field_cnt #(.MAX(MIN_MAX), .BCD(BCD)) u_min (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (i_clear),
    .i_up        (w_min_up),
    .i_down      (w_min_dn),
    .o_value     (w_min),
    .o_carry_out (w_min_max),
    .o_borrow_out(w_min_zero)
  );

  time_field_cnt #(.MAX(HOUR_MAX), .BCD(BCD)) u_hour (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (i_clear),
    .i_up        (w_hour_up),
    .i_down      (w_hour_dn),
    .o_value     (w_hour),
    .o_carry_out (w_hour_max),
    .o_borrow_out(w_hour_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inc_prev  <= 1'b0;
      r_dec_prev  <= 1'b0;
      r_day_carry <= 1'b0;
      r_expired   <= 1'b0;
    end else begin
      r_inc_prev  <= i_inc_btn;
      r_dec_prev  <= i_dec_btn;
      r_day_carry <= w_tick_up & w_sec_max & w_min_max & w_hour_max & ~i_clear;
      // Only the 0:0:1 -> 0:0:0 step expires; ticks at zero are already masked.
      r_expired   <= w_tick_dn & (w_sec == 8'd1) & w_min_zero & w_hour_zero & ~i_clear;
    end
  end

  always_comb begin
    w_hour_bin = BCD ? (8'(w_hour[7:4]) * 8'd10 + 8'(w_hour[3:0])) : w_hour;
    w_disp_bin = w_hour_bin;
    if (w_hour_bin == 8'd0) begin
      w_disp_bin = 8'd12;
    end else if (w_hour_bin > 8'd12) begin
      w_disp_bin = w_hour_bin - 8'd12;
    end
    o_hour_disp = w_hour;
    if (i_hour12) begin
      o_hour_disp = (BCD && w_disp_bin >= 8'd10) ? {4'd1, 4'(w_disp_bin - 8'd10)} : w_disp_bin;
    end
  end

  assign o_pm          = (w_hour_bin >= 8'd12);
  assign o_second_data = w_sec;
  assign o_minute_data = w_min;
  assign o_hour_data   = w_hour;
  assign o_day_carry   = r_day_carry;
  assign o_expired     = r_expired;

endmodule
